gcd_arbiter: RTL and testbench

//   Shares one gcd core among N requesters. Round-robin picks one request, then

---
 rtl/gcd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one multi-cycle gcd core among N requesters.
//   A round-robin arbiter picks one pending request and forwards its operands to the
//   core with a single start pulse. It captures the result on core_done and returns
//   it to the winning requester over a valid/ready response channel.
//   Operands containing a zero bypass the core. A core that hangs produces an error
//   response after TIMEOUT cycles.
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   req_valid/ready, req_opa/opb   request channel; requester i at bit i / [i*W +: W]
//   rsp_valid/ready, rsp_result, rsp_err   response channel; rsp_valid is one-hot
//   core_opa/opb/start, core_result/done   gcd core interface
//   busy                      transaction in flight
module gcd_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_opa,
  input  logic [N*W-1:0] req_opb,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_err,
  input  logic [N-1:0]   rsp_ready,
  output logic [W-1:0]   core_opa,
  output logic [W-1:0]   core_opb,
  output logic           core_start,
  input  logic [W-1:0]   core_result,
  input  logic           core_done,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e         state_q,      state_d;
  logic [IW-1:0]  rr_ptr_q,     rr_ptr_d;
  logic [IW-1:0]  grant_q,      grant_d;
  logic [W-1:0]   opa_q,        opa_d;
  logic [W-1:0]   opb_q,        opb_d;
  logic [W-1:0]   result_q,     result_d;
  logic           err_q,        err_d;
  logic [TW-1:0]  timer_q,      timer_d;
  logic           core_start_q, core_start_d;
  logic [N-1:0]   rsp_valid_q,  rsp_valid_d;
  logic           busy_q,       busy_d;

  // Round-robin pick: first valid requester scanning from rr_ptr upward, modulo N.
  logic [IW-1:0]  cand, win_idx;
  logic           win_found;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic [W-1:0] win_opa, win_opb;
  logic [N-1:0] win_oh, grant_oh;
  logic         accept;

  assign win_opa  = req_opa[int'(win_idx)*W +: W];
  assign win_opb  = req_opb[int'(win_idx)*W +: W];
  assign win_oh   = N'(1) << win_idx;
  assign grant_oh = N'(1) << grant_q;
  // ready is only offered in IDLE; gating with resetn keeps every output low in reset
  assign accept    = (state_q == S_IDLE) && win_found && resetn;
  assign req_ready = accept ? win_oh : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    err_d        = err_q;
    timer_d      = timer_q;
    rsp_valid_d  = rsp_valid_q;
    core_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          grant_d = win_idx;
          opa_d   = win_opa;
          opb_d   = win_opb;
          timer_d = '0;
          if (win_opa == '0 || win_opb == '0) begin
            // gcd(x,0)=x and gcd(0,0)=0, so OR of the operands is the answer
            result_d    = win_opa | win_opb;
            err_d       = 1'b0;
            rsp_valid_d = win_oh;
            state_d     = S_RESP;
          end else begin
            core_start_d = 1'b1;
            state_d      = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        // timer counts cycles since LAUNCH, so timeout lands exactly TIMEOUT cycles later
        timer_d = timer_q + TW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (core_done) begin
          result_d    = core_result;
          err_d       = 1'b0;
          rsp_valid_d = grant_oh;
          state_d     = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          result_d    = '0;
          err_d       = 1'b1;
          rsp_valid_d = grant_oh;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (int'(grant_q) == N - 1) ? '0 : grant_q + IW'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      timer_q      <= '0;
      core_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      result_q     <= result_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
      core_start_q <= core_start_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  // operand latches stay put from LAUNCH through WAIT, so they feed the core directly
  assign core_opa   = opa_q;
  assign core_opb   = opb_q;
  assign core_start = core_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: scoreboard bench for gcd_arbiter with a behavioural gcd core.
//   Expected responses are queued at request acceptance and popped at response handshake.
module tb_gcd_arbiter;
  localparam int N = 4, W = 32, TIMEOUT = 16, CORE_LAT = 10;

  logic           clk = 1'b0, resetn = 1'b0;
  logic [N-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [N*W-1:0] req_opa = '0, req_opb = '0;
  logic [W-1:0]   rsp_result, core_opa, core_opb, core_result = '0;
  logic           rsp_err, core_start, core_done = 1'b0, busy;

  gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_opa(req_opa), .req_opb(req_opb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .core_opa(core_opa), .core_opb(core_opb), .core_start(core_start),
    .core_result(core_result), .core_done(core_done), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int lane; logic [W-1:0] res; logic err; } exp_t;
  exp_t exp_q[$];
  int   acc_log[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_start = 0, n_rsp = 0, n_done = 0;
  int acc_cyc = 0, start_cyc = 0, done_cyc = 0, rv_cyc = 0, cm_cnt = 0;
  logic prev_rv = 1'b0, hang = 1'b0;
  logic [W-1:0] cm_a = '0, cm_b = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  function automatic int lane_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_opa[i*W +: W] = a;
    req_opb[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  // One clock: core model, response monitor, request acceptance, then drop accepted valid.
  task automatic tick();
    int   hs = -1;
    exp_t e;
    logic [W-1:0] a, b;
    @(negedge clk);
    cyc++;
    core_done = 1'b0;
    if (core_start) begin
      n_start++; start_cyc = cyc; cm_a = core_opa; cm_b = core_opb; cm_cnt = CORE_LAT;
    end else if (cm_cnt > 0) begin
      cm_cnt--;
      if (cm_cnt == 0 && !hang) begin
        core_result = gcd_ref(cm_a, cm_b); core_done = 1'b1; done_cyc = cyc; n_done++;
      end
    end
    if (rsp_valid != 0 && !prev_rv) rv_cyc = cyc;
    prev_rv = (rsp_valid != 0);
    if ((rsp_valid & rsp_ready) != 0) begin
      n_rsp++;
      chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_lane", 64'(lane_of(rsp_valid)), 64'(e.lane));
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
    if ((req_valid & req_ready) != 0) begin
      hs = lane_of(req_valid & req_ready);
      acc_cyc = cyc;
      acc_log.push_back(hs);
      a = req_opa[hs*W +: W];
      b = req_opb[hs*W +: W];
      e.lane = hs;
      if (a == 0 || b == 0) begin e.res = a | b;        e.err = 1'b0; end
      else if (hang)        begin e.res = '0;           e.err = 1'b1; end
      else                  begin e.res = gcd_ref(a, b); e.err = 1'b0; end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (hs >= 0) req_valid[hs] = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    int k = 0;
    while (n_rsp < target && k < 200) begin tick(); k++; end
    if (n_rsp < target) chk("wait_tx_bound", 64'(n_rsp), 64'(target));
  endtask

  task automatic wait_acc(input int target);
    int k = 0;
    while (acc_log.size() < target && k < 100) begin tick(); k++; end
    if (acc_log.size() < target) chk("wait_acc_bound", 64'(acc_log.size()), 64'(target));
  endtask

  initial begin
    int s0, r0, rst_cyc, rv_seen;
    // reset state
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp", 64'({rsp_err, rsp_result}), 0);
    chk("rst_core", 64'({core_start, core_opa}), 0);
    chk("rst_core_opb", 64'(core_opb), 0);
    chk("rst_busy", 64'(busy), 0);
    resetn = 1'b1;
    tick();

    // fairness: all valid -> grants 0,1,2,3,0
    acc_log.delete();
    post(0, 48, 36); post(1, 100, 75); post(2, 81, 27); post(3, 17, 5);
    wait_acc(1);
    post(0, 56, 98);
    wait_tx(5);
    chk("rr_count", 64'(acc_log.size()), 5);
    for (int i = 0; i < 5 && i < acc_log.size(); i++) chk("rr_order", 64'(acc_log[i]), 64'(i % N));

    // single request through the core
    s0 = n_start; r0 = n_rsp;
    post(0, 1071, 462);
    wait_tx(r0 + 1);
    chk("t1_starts", 64'(n_start - s0), 1);
    chk("t1_start_lat", 64'(start_cyc - acc_cyc), 1);
    chk("t1_core_opa", 64'(cm_a), 1071);
    chk("t1_core_opb", 64'(cm_b), 462);
    chk("t1_rsp_lat", 64'(rv_cyc - done_cyc), 1);

    // zero-operand bypass
    s0 = n_start; r0 = n_rsp;
    post(2, 0, 35);
    wait_tx(r0 + 1);
    chk("t3_bypass_lat", 64'(rv_cyc - acc_cyc), 1);
    post(2, 0, 0);
    wait_tx(r0 + 2);
    chk("t3_no_start", 64'(n_start - s0), 0);

    // hung core -> timeout error, then normal service
    hang = 1'b1;
    r0 = n_rsp;
    post(1, 12, 8);
    wait_tx(r0 + 1);
    chk("t4_timeout_lat", 64'(rv_cyc - start_cyc), TIMEOUT);
    hang = 1'b0;
    post(3, 9, 6);
    wait_tx(r0 + 2);

    // response backpressure
    rsp_ready = '0;
    r0 = n_rsp;
    post(3, 48, 18);
    for (int k = 0; k < 60 && rsp_valid == 0; k++) tick();
    chk("t5_rsp_arrived", 64'(rsp_valid), 64'd8);
    s0 = n_start;
    post(0, 14, 21);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t5_hold_valid", 64'(rsp_valid), 64'd8);
      chk("t5_hold_result", 64'(rsp_result), 64'd6);
      chk("t5_req_ready", 64'(req_ready), 0);
    end
    chk("t5_no_start", 64'(n_start - s0), 0);
    rsp_ready = '1;
    wait_tx(r0 + 2);

    // reset while waiting on the core
    s0 = n_start;
    post(2, 100, 75);
    for (int k = 0; k < 20 && n_start == s0; k++) tick();
    repeat (3) tick();
    chk("t6_in_wait", 64'(busy), 1);
    resetn = 1'b0;
    rst_cyc = cyc;
    tick();
    chk("t6_rst_valid", 64'({req_ready, rsp_valid}), 0);
    chk("t6_rst_core", 64'({core_start, core_opa}), 0);
    chk("t6_rst_busy", 64'({busy, rsp_err, rsp_result}), 0);
    tick();
    resetn = 1'b1;
    exp_q.delete();
    rv_seen = 0;
    for (int k = 0; k < 15; k++) begin tick(); if (rsp_valid != 0) rv_seen++; end
    chk("t6_done_after_rst", 64'(done_cyc > rst_cyc), 1);
    chk("t6_no_rsp", 64'(rv_seen), 0);
    chk("t6_idle", 64'(busy), 0);
    acc_log.delete();
    r0 = n_rsp;
    post(3, 27, 18); post(0, 40, 24);
    wait_acc(1);
    if (acc_log.size() > 0) chk("t6_first_grant", 64'(acc_log[0]), 0);
    wait_tx(r0 + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
